// File: rtl/mac_tile_acc_mult.sv
// Tiled matrix multiplier: computes C = A x B one LANES-wide strip of a C row per pass,
// with a full K-deep accumulation per pass and a valid/ready result stream.
module mac_tile_acc_mult #(
  parameter int M          = 2,
  parameter int K          = 2,
  parameter int N          = 4,
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K),
  localparam int RW = (M > 1) ? $clog2(M) : 1,
  localparam int KW = (K > 1) ? $clog2(K) : 1,
  localparam int NW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stall,
  input  logic [DATA_WIDTH-1:0]         data_in_a,
  input  logic [LANES*DATA_WIDTH-1:0]   data_in_b,
  output logic                          rd_en,
  output logic [RW-1:0]                 row_addr_a,
  output logic [KW-1:0]                 col_addr_a,
  output logic [KW-1:0]                 row_addr_b,
  output logic [NW-1:0]                 col_base_b,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [LANES*ACC_WIDTH-1:0]    result_data,
  output logic [RW-1:0]                 result_row,
  output logic [NW-1:0]                 result_col_base,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_WAIT, ST_OUT, ST_DONE} state_e;

  localparam logic [KW-1:0] K_LAST   = KW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [NW-1:0] COL_LAST = NW'(N - LANES);
  localparam logic [NW-1:0] COL_STEP = NW'(LANES);

  state_e                 state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [KW-1:0]          k_q, k_d;
  logic [NW-1:0]          col_q, col_d;
  logic                   valid_q;
  logic                   acc_clr;
  logic [ACC_WIDTH-1:0]   acc_q [LANES];
  logic [ACC_WIDTH-1:0]   acc_d [LANES];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      k_q     <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
      col_q   <= col_d;
      valid_q <= rd_en;
      for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
    end
  end

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    k_d     = k_q;
    col_d   = col_q;
    acc_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
          acc_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (k_q == K_LAST) begin
            state_d = ST_WAIT;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      ST_WAIT: state_d = ST_OUT;
      ST_OUT: begin
        if (result_ready) begin
          if (row_q == ROW_LAST && col_q == COL_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            k_d     = '0;
            acc_clr = 1'b1;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + COL_STEP;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en        = (state_q == ST_RUN) && !stall;
    result_valid = (state_q == ST_OUT);
    busy         = (state_q == ST_RUN) || (state_q == ST_WAIT) || (state_q == ST_OUT);
    done         = (state_q == ST_DONE);
  end

  // Operand data arrives one cycle after rd_en; valid_q marks that cycle.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      acc_d[l] = acc_q[l];
      if (acc_clr) begin
        acc_d[l] = '0;
      end else if (valid_q) begin
        acc_d[l] = acc_q[l] + ACC_WIDTH'(data_in_a) *
                   ACC_WIDTH'(data_in_b[l*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  always_comb begin
    result_data = '0;
    for (int l = 0; l < LANES; l++) result_data[l*ACC_WIDTH +: ACC_WIDTH] = acc_q[l];
  end

  assign row_addr_a      = row_q;
  assign col_addr_a      = k_q;
  assign row_addr_b      = k_q;
  assign col_base_b      = col_q;
  assign result_row      = row_q;
  assign result_col_base = col_q;

endmodule

// File: tb/tb_mac_tile_acc_mult.sv
// Bench for mac_tile_acc_mult: directed runs with a beat scoreboard checked by an
// independent monitor, plus per-run timing checks on done, busy and rd_en.
module tb_mac_tile_acc_mult;

  localparam int M = 2, K = 2, N = 4, LANES = 2, DW = 8;
  localparam int AW = 2*DW + $clog2(K);

  logic              clk = 1'b0;
  logic              reset, start, stall, result_ready;
  logic [DW-1:0]     data_in_a;
  logic [LANES*DW-1:0] data_in_b;
  logic              rd_en, result_valid, busy, done;
  logic [0:0]        row_addr_a, col_addr_a, row_addr_b, result_row;
  logic [1:0]        col_base_b, result_col_base;
  logic [LANES*AW-1:0] result_data;

  mac_tile_acc_mult #(.M(M), .K(K), .N(N), .LANES(LANES), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .data_in_a(data_in_a), .data_in_b(data_in_b), .rd_en(rd_en),
    .row_addr_a(row_addr_a), .col_addr_a(col_addr_a), .row_addr_b(row_addr_b),
    .col_base_b(col_base_b), .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .result_row(result_row),
    .result_col_base(result_col_base), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    int d0;
    int d1;
    int rel;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int a_mem [M][K];
  int b_mem [K][N];

  always @(posedge clk) cyc <= cyc + 1;

  // Operand memories with one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      data_in_a <= DW'(a_mem[row_addr_a][col_addr_a]);
      for (int l = 0; l < LANES; l++)
        data_in_b[l*DW +: DW] <= DW'(b_mem[row_addr_b][int'(col_base_b) + l]);
    end
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  // Monitor: every presented beat must match the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got row %0d col %0d, expected no beat",
                 result_row, result_col_base);
      end else begin
        mon_e = sb[0];
        check("beat_row", result_row, mon_e.row);
        check("beat_col", result_col_base, mon_e.col);
        check("beat_lane0", result_data[AW-1:0], mon_e.d0);
        check("beat_lane1", result_data[2*AW-1:AW], mon_e.d1);
        if (result_ready) begin
          check("beat_cycle", cyc - t0, mon_e.rel);
          sb.delete(0);
        end
      end
    end
  end

  task automatic push(input int row, input int col, input int d0, input int d1, input int rel);
    beat_t b;
    b.row = row; b.col = col; b.d0 = d0; b.d1 = d1; b.rel = rel;
    sb.push_back(b);
  endtask

  task automatic load(input bit max_vals);
    for (int r = 0; r < M; r++)
      for (int k = 0; k < K; k++) a_mem[r][k] = max_vals ? 255 : r*K + k + 1;
    for (int k = 0; k < K; k++)
      for (int c = 0; c < N; c++) b_mem[k][c] = max_vals ? 255 : k*N + c + 1;
  endtask

  task automatic push_basic(input int r0, input int r1, input int r2, input int r3);
    push(0, 0, 11, 14, r0);
    push(0, 2, 17, 20, r1);
    push(1, 0, 23, 30, r2);
    push(1, 2, 37, 44, r3);
  endtask

  // Drives one operation; rel is the cycle number counted from the start cycle.
  task automatic run_op(input int stall_from, input int stall_to,
                        input int ready_from, input int ready_to,
                        input int restart_at, input int reset_at,
                        input int exp_done, input int exp_busy, input int exp_rd);
    int done_at = -1, busy_n = 0, rd_n = 0, freeze_err = 0, bp_rd = 0;
    int limit = (exp_done < 0) ? 30 : 60;
    logic [2:0] prev_addr = '0;
    for (int rel = 0; rel < limit && !(exp_done >= 0 && done_at >= 0); rel++) begin
      @(posedge clk); #1;
      if (rel == 0) t0 = cyc;
      start        = (rel == 0) || (rel == restart_at);
      stall        = (rel >= stall_from) && (rel <= stall_to);
      result_ready = !((rel >= ready_from) && (rel <= ready_to));
      reset        = (rel == reset_at);
      @(negedge clk);
      if (busy) busy_n++;
      if (rd_en) rd_n++;
      if (done && done_at < 0) done_at = rel;
      if (stall && rd_en) freeze_err++;
      if (rel > stall_from && rel <= stall_to && {row_addr_a, col_addr_a, col_base_b} != prev_addr)
        freeze_err++;
      if (!result_ready && rd_en) bp_rd++;
      if (rel == reset_at + 1) begin
        check("post_reset_busy", busy, 0);
        check("post_reset_rd_en", rd_en, 0);
        check("post_reset_valid", result_valid, 0);
      end
      prev_addr = {row_addr_a, col_addr_a, col_base_b};
    end
    start = 1'b0; stall = 1'b0; result_ready = 1'b1; reset = 1'b0;
    if (exp_done >= 0) check("done_cycle", done_at, exp_done);
    else check("no_done_after_reset", done_at, -1);
    if (exp_busy >= 0) check("busy_cycles", busy_n, exp_busy);
    if (exp_rd >= 0) check("rd_en_cycles", rd_n, exp_rd);
    if (stall_from >= 0) check("stall_freeze_errs", freeze_err, 0);
    if (ready_from >= 0) check("rd_en_in_backpressure", bp_rd, 0);
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; result_ready = 1'b1;
    data_in_a = '0; data_in_b = '0;
    load(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_en", rd_en, 0);
    check("reset_valid", result_valid, 0);
    check("reset_data", result_data, 0);
    check("reset_addr", {row_addr_a, col_addr_a, row_addr_b, col_base_b}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Basic multiply
    push_basic(4, 8, 12, 16);
    run_op(-1, -1, -1, -1, -1, -1, 17, 16, 8);

    // Stall for cycles 2-4
    push_basic(7, 11, 15, 19);
    run_op(2, 4, -1, -1, -1, -1, 20, 19, 8);

    // Backpressure for cycles 4-9
    push_basic(10, 14, 18, 22);
    run_op(-1, -1, 4, 9, -1, -1, 23, 22, 8);

    // Maximum operand values
    load(1'b1);
    push(0, 0, 130050, 130050, 4);
    push(0, 2, 130050, 130050, 8);
    push(1, 0, 130050, 130050, 12);
    push(1, 2, 130050, 130050, 16);
    run_op(-1, -1, -1, -1, -1, -1, 17, 16, 8);

    // Reset mid-run, then a clean run from the beginning
    load(1'b0);
    push(0, 0, 11, 14, 4);
    run_op(-1, -1, -1, -1, -1, 6, -1, -1, -1);
    push_basic(4, 8, 12, 16);
    run_op(-1, -1, -1, -1, -1, -1, 17, 16, 8);

    // start pulsed while busy
    push_basic(4, 8, 12, 16);
    run_op(-1, -1, -1, -1, 5, -1, 17, 16, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_tile_acc_mult.md
Name: mac_tile_acc_mult

Overview:
- Parametrised successor to the single-lane stop-and-go matrix multiplier.
- Computes C = A x B (A is MxK, B is KxN) with LANES parallel output columns per pass and a full K-deep accumulation per output.
- Adds a start/busy/done handshake, a stall input, and a valid/ready result stream.
- Sits between the A/B operand memories (1-cycle read latency) and the result writer.

Parameters:
- M, 2, rows of A and C
- K, 2, columns of A and rows of B (accumulation depth)
- N, 4, columns of B and C; must be a multiple of LANES
- LANES, 2, output columns computed per pass
- DATA_WIDTH, 8, unsigned operand width
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(K), per-lane accumulator and result width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a full multiply; sampled only in IDLE
- stall  in  1  freezes read issue while high
- data_in_a  in  DATA_WIDTH  A[row][k], valid the cycle after rd_en
- data_in_b  in  LANES*DATA_WIDTH  B[k][col_base+l] in lane l, valid the cycle after rd_en
- rd_en  out  1  read enable to both operand memories
- row_addr_a  out  $clog2(M)  A row
- col_addr_a  out  $clog2(K)  A column (k)
- row_addr_b  out  $clog2(K)  B row (k)
- col_base_b  out  $clog2(N)  B column of lane 0
- result_valid  out  1  result beat available
- result_ready  in  1  consumer accepts the beat
- result_data  out  LANES*ACC_WIDTH  lane l at bits [l*ACC_WIDTH +: ACC_WIDTH]
- result_row  out  $clog2(M)  C row of the beat
- result_col_base  out  $clog2(N)  C column of lane 0
- busy  out  1  high in RUN, WAIT and OUT
- done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset forces state IDLE. All outputs, counters and accumulators are 0.
- Reset mid-operation aborts the operation. No done pulse is produced.
- State IDLE: start=1 moves to RUN with row=0, col_base=0, k=0, and all accumulators cleared.
- State RUN:
  - With stall=0: rd_en=1 with the current addresses, and k increments.
  - When k=K-1 is issued, move to WAIT.
  - With stall=1: rd_en=0, and all counters hold.
- Data pipeline: a 1-bit valid register captures rd_en. When it is set, each lane does acc[l] += data_in_a * data_in_b[l], unsigned and full width, with no saturation.
- Stall does not block in-flight data.
- State WAIT: one cycle for the last product to accumulate, then move to OUT.
- State OUT:
  - result_valid=1; result_data, result_row and result_col_base are held stable until result_ready=1.
  - On handshake, if row=M-1 and col_base=N-LANES, go to DONE.
  - Otherwise advance col_base by LANES. On wrap (col_base=N-LANES), col_base goes to 0 and row increments.
  - In either non-final case, clear the accumulators, set k=0, and return to RUN.
- State DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Per-pass latency with stall=0 and result_ready=1: K+2 cycles. rd_en is high in cycles c..c+K-1 and result_valid is high in cycle c+K+1.
- The first rd_en is in the cycle after start is sampled.
- start while busy is ignored. stall outside RUN has no effect.
- result_ready outside OUT has no effect.
- Overflow: ACC_WIDTH makes overflow impossible for unsigned operands.
- Degenerate case K=1: RUN lasts exactly one cycle per pass.

Test Plan:
- Basic multiply (default parameters, A=[[1,2],[3,4]], B=[[1,2,3,4],[5,6,7,8]], start at cycle 0, result_ready=1, stall=0):
  - Beats in order: (row 0, col 0) [11,14], (row 0, col 2) [17,20], (row 1, col 0) [23,30], (row 1, col 2) [37,44].
  - Beats appear at cycles 4, 8, 12 and 16; done=1 at cycle 17; busy=1 for cycles 1-16.
- Stall: same data with stall=1 for cycles 2-4 -> rd_en=0 in those cycles and addresses frozen; results are identical; every later event shifts by 3 cycles (done at cycle 20).
- Backpressure: result_ready=0 for cycles 4-9 -> beat [11,14] is held stable through cycles 4-10; no rd_en in that window; done at cycle 23.
- Maximum values: all operands 255 -> every lane is 130050 (0x1FC02, fits in 17 bits).
- Reset mid-run: reset=1 at cycle 6 -> next cycle busy=0, rd_en=0, result_valid=0; no done pulse. A new start computes correct results from the beginning.
- start pulsed at cycle 5 while busy -> no effect on addresses, results or done timing.
